// File: rtl/ff_sweep_core.sv
// Flip-flop phase sweep core: steps a phase shifter and counts '1' samples per channel.
// Bus latency: NATIVE_READY and read data one cycle after NATIVE_EN; sweep runs autonomously.
// No backpressure: every bus request completes in one cycle; abort preempts any state.
// Optional feature macro: FF_SWEEP_TIMEOUT_EN (bounds WAIT_DONE by TIMEOUT cycles).
module ff_sweep_core #(
  parameter int NATIVE_ADDR_WIDTH = 3,
  parameter int NATIVE_DATA_WIDTH = 32,
  parameter int CHANNELS          = 4,
  parameter int M                 = 100,
  parameter int SETTLE            = 8,
  parameter int TIMEOUT           = 1024
) (
  input  logic                         REFCLK,
  input  logic                         rst_n,
  input  logic                         NATIVE_EN,
  input  logic                         NATIVE_WR,
  input  logic [NATIVE_ADDR_WIDTH-1:0] NATIVE_ADDR,
  input  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN,
  output logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT,
  output logic                         NATIVE_READY,
  input  logic [CHANNELS-1:0]          imp_in,
  output logic                         ps_en,
  output logic                         ps_incdec,
  input  logic                         ps_done,
  output logic                         ps_clk,
  output logic                         busy,
  output logic                         proba_signal
);

  localparam int DW         = NATIVE_DATA_WIDTH;
  localparam int CW         = $clog2(M + 1);
  localparam int TOTW       = CW + $clog2(CHANNELS);
  localparam int SETTLE_LEN = (SETTLE == 0) ? 1 : SETTLE;
  localparam int TMAX_A     = (SETTLE_LEN > M) ? SETTLE_LEN : M;
  localparam int TMAX       = (TIMEOUT > TMAX_A) ? TIMEOUT : TMAX_A;
  localparam int TW         = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SHIFT, ST_WAIT_DONE, ST_SETTLE, ST_SAMPLE, ST_STORE, ST_DONE
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   timer;
  logic [15:0]     steps;
  logic [15:0]     step;
  logic [2:0]      ch_sel;
  logic            dir_q;
  logic            done_q, aborted_q, timeout_q;
  logic [CW-1:0]   cnt    [CHANNELS];
  logic [CW-1:0]   result [CHANNELS];
  logic [TOTW-1:0] total;
  logic [TOTW-1:0] cnt_sum;
  logic [DW-1:0]   rd_mux;
  logic            bus_wr, bus_rd, start_req, abort_req, start_acc, timeout_hit;

  // Only the low 16 data bits carry register content.
  logic unused_data;
  assign unused_data = &{1'b0, NATIVE_DATA_IN[DW-1:16]};

  assign ps_clk    = REFCLK;
  assign ps_incdec = dir_q;

  assign bus_wr    = NATIVE_EN & NATIVE_WR;
  assign bus_rd    = NATIVE_EN & ~NATIVE_WR;
  assign start_req = bus_wr && (NATIVE_ADDR == NATIVE_ADDR_WIDTH'(0)) && NATIVE_DATA_IN[0];
  assign abort_req = bus_wr && (NATIVE_ADDR == NATIVE_ADDR_WIDTH'(0)) && NATIVE_DATA_IN[2];
  // Start only counts from IDLE; abort in the same write overrides it.
  assign start_acc = start_req && !abort_req && (state == ST_IDLE);

`ifdef FF_SWEEP_TIMEOUT_EN
  assign timeout_hit = (state == ST_WAIT_DONE) && !ps_done && !abort_req &&
                       (timer == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge REFCLK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start_acc) state_next = (steps == 16'd0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT:     state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (ps_done)          state_next = ST_SETTLE;
        else if (timeout_hit) state_next = ST_DONE;
      end
      ST_SETTLE:    if (timer == TW'(SETTLE_LEN - 1)) state_next = ST_SAMPLE;
      ST_SAMPLE:    if (timer == TW'(M - 1)) state_next = ST_STORE;
      ST_STORE:     state_next = ((step + 16'd1) < steps) ? ST_SHIFT : ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
    if (abort_req) state_next = ST_IDLE;
  end

  // Outputs decoded from the current state.
  always_comb begin
    ps_en        = (state == ST_SHIFT);
    proba_signal = (state == ST_SAMPLE);
    busy         = (state != ST_IDLE) && (state != ST_DONE);
  end

  // Cycle timer, restarted on every state change.
  always_ff @(posedge REFCLK or negedge rst_n) begin
    if (!rst_n)                  timer <= '0;
    else if (state_next != state) timer <= '0;
    else                         timer <= timer + TW'(1);
  end

  // Per-channel sample counters and result capture.
  always_ff @(posedge REFCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i]    <= '0;
        result[i] <= '0;
      end
      total <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (state == ST_SAMPLE)
          cnt[i] <= cnt[i] + CW'(imp_in[i]);
        else if (state == ST_STORE || state == ST_IDLE)
          cnt[i] <= '0;
        if (state == ST_STORE && !abort_req)
          result[i] <= cnt[i];
      end
      if (state == ST_STORE && !abort_req) total <= cnt_sum;
    end
  end

  // Sum of all live counters, captured into TOTAL at STORE.
  always_comb begin
    cnt_sum = '0;
    for (int i = 0; i < CHANNELS; i++) cnt_sum = cnt_sum + TOTW'(cnt[i]);
  end

  // Step index, direction latch and sticky status flags.
  always_ff @(posedge REFCLK or negedge rst_n) begin
    if (!rst_n) begin
      step      <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (abort_req) begin
      aborted_q <= 1'b1;
    end else if (start_acc) begin
      step      <= '0;
      dir_q     <= NATIVE_DATA_IN[1];
      done_q    <= (steps == 16'd0);
      aborted_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_STORE) step <= step + 16'd1;
      if (state_next == ST_DONE && state != ST_DONE) done_q <= 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  // Read data selection.
  always_comb begin
    rd_mux = '0;
    case (NATIVE_ADDR)
      NATIVE_ADDR_WIDTH'(1): rd_mux = DW'(steps);
      NATIVE_ADDR_WIDTH'(2): rd_mux = DW'({step, 12'd0, timeout_q, aborted_q, done_q, busy});
      NATIVE_ADDR_WIDTH'(3): rd_mux = DW'(ch_sel);
      NATIVE_ADDR_WIDTH'(4): begin
        for (int i = 0; i < CHANNELS; i++)
          if (ch_sel == 3'(i)) rd_mux = DW'(result[i]);
      end
      NATIVE_ADDR_WIDTH'(5): rd_mux = DW'(total);
      default:               rd_mux = '0;
    endcase
  end

  // Bus completion, read data hold and configuration registers.
  always_ff @(posedge REFCLK or negedge rst_n) begin
    if (!rst_n) begin
      NATIVE_READY    <= 1'b0;
      NATIVE_DATA_OUT <= '0;
      steps           <= '0;
      ch_sel          <= '0;
    end else begin
      NATIVE_READY <= NATIVE_EN;
      if (bus_rd) NATIVE_DATA_OUT <= rd_mux;
      if (bus_wr && NATIVE_ADDR == NATIVE_ADDR_WIDTH'(1)) steps  <= NATIVE_DATA_IN[15:0];
      if (bus_wr && NATIVE_ADDR == NATIVE_ADDR_WIDTH'(3)) ch_sel <= NATIVE_DATA_IN[2:0];
    end
  end

endmodule

// File: tb/tb_ff_sweep_core.sv
// Directed bench for ff_sweep_core: bus access, sweeps, toggle counting, abort, timeout, reset.
// Expected values are hand-computed constants; ps_done is returned 3 cycles after each ps_en.
module tb_ff_sweep_core;

  logic        REFCLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        NATIVE_EN = 1'b0;
  logic        NATIVE_WR = 1'b0;
  logic [2:0]  NATIVE_ADDR = '0;
  logic [31:0] NATIVE_DATA_IN = '0;
  logic [31:0] NATIVE_DATA_OUT;
  logic        NATIVE_READY;
  logic [3:0]  imp_in = '0;
  logic        ps_en, ps_incdec, ps_clk, busy, proba_signal;
  logic        ps_done = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int pe_cnt  = 0;
  logic       auto_done = 1'b1;
  logic       tog_mode  = 1'b0;
  logic       tog       = 1'b0;
  logic [3:0] pattern   = 4'b0101;

  ff_sweep_core #(
    .NATIVE_ADDR_WIDTH(3), .NATIVE_DATA_WIDTH(32), .CHANNELS(4),
    .M(100), .SETTLE(8), .TIMEOUT(16)
  ) dut (
    .REFCLK(REFCLK), .rst_n(rst_n),
    .NATIVE_EN(NATIVE_EN), .NATIVE_WR(NATIVE_WR), .NATIVE_ADDR(NATIVE_ADDR),
    .NATIVE_DATA_IN(NATIVE_DATA_IN), .NATIVE_DATA_OUT(NATIVE_DATA_OUT),
    .NATIVE_READY(NATIVE_READY), .imp_in(imp_in),
    .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done), .ps_clk(ps_clk),
    .busy(busy), .proba_signal(proba_signal)
  );

  always #5 REFCLK = ~REFCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Sample channel inputs; bit 2 optionally toggles every cycle.
  initial forever begin
    @(negedge REFCLK);
    tog = ~tog;
    imp_in = tog_mode ? {1'b0, tog, 1'b0, 1'b1} : pattern;
  end

  // Count ps_en pulses.
  initial forever begin
    @(negedge REFCLK);
    if (ps_en) pe_cnt++;
  end

  // Phase shifter model: ps_done pulse 3 cycles after ps_en.
  initial forever begin
    @(negedge REFCLK);
    if (ps_en && auto_done) begin
      repeat (3) @(negedge REFCLK);
      ps_done = 1'b1;
      @(negedge REFCLK);
      ps_done = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge REFCLK);
    NATIVE_EN = 1'b1; NATIVE_WR = 1'b1; NATIVE_ADDR = a; NATIVE_DATA_IN = d;
    @(negedge REFCLK);
    NATIVE_EN = 1'b0; NATIVE_WR = 1'b0;
    chk("wr_ready", {31'd0, NATIVE_READY}, 32'd1);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge REFCLK);
    NATIVE_EN = 1'b1; NATIVE_WR = 1'b0; NATIVE_ADDR = a;
    @(negedge REFCLK);
    NATIVE_EN = 1'b0;
    chk("rd_ready", {31'd0, NATIVE_READY}, 32'd1);
    d = NATIVE_DATA_OUT;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge REFCLK);
      n++;
    end
    chk("wait_idle_bound", {31'd0, (n < lim)}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int base;
    int n;

    // Reset state
    repeat (3) @(negedge REFCLK);
    chk("rst_ready", {31'd0, NATIVE_READY}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ps_en", {31'd0, ps_en}, 32'd0);
    chk("rst_proba", {31'd0, proba_signal}, 32'd0);
    chk("rst_dout",  NATIVE_DATA_OUT, 32'd0);
    rst_n = 1'b1;
    bus_read(3'd1, rd); chk("rst_steps", rd, 32'd0);
    bus_read(3'd2, rd); chk("rst_status", rd, 32'd0);

    // Bus write/read of STEPS, ready pulse width, read data hold
    bus_write(3'd1, 32'd5);
    bus_read(3'd1, rd); chk("steps_rd", rd, 32'd5);
    @(negedge REFCLK);
    chk("ready_one_cycle", {31'd0, NATIVE_READY}, 32'd0);
    bus_write(3'd3, 32'd0);
    chk("dout_held", NATIVE_DATA_OUT, 32'd5);

    // Unmapped address reads zero
    bus_write(3'd6, 32'hdead_beef);
    bus_read(3'd6, rd); chk("unmapped", rd, 32'd0);

    // Three-step sweep, imp_in = 0101, dir = 1
    pattern = 4'b0101;
    bus_write(3'd1, 32'd3);
    base = pe_cnt;
    bus_write(3'd0, 32'd3);
    chk("incdec_dir1", {31'd0, ps_incdec}, 32'd1);
    wait_idle(2000);
    chk("sweep_ps_en", pe_cnt - base, 32'd3);
    bus_read(3'd2, rd); chk("sweep_status", rd, 32'h0003_0002);
    bus_write(3'd3, 32'd0); bus_read(3'd4, rd); chk("sweep_ch0", rd, 32'd100);
    bus_write(3'd3, 32'd1); bus_read(3'd4, rd); chk("sweep_ch1", rd, 32'd0);
    bus_write(3'd3, 32'd2); bus_read(3'd4, rd); chk("sweep_ch2", rd, 32'd100);
    bus_read(3'd5, rd); chk("sweep_total", rd, 32'd200);

    // Toggling channel 2 yields half of M
    tog_mode = 1'b1;
    bus_write(3'd1, 32'd1);
    bus_write(3'd0, 32'd1);
    wait_idle(1000);
    bus_read(3'd4, rd); chk("toggle_ch2", rd, 32'd50);
    bus_read(3'd5, rd); chk("toggle_total", rd, 32'd150);
    tog_mode = 1'b0;

    // Abort during second SAMPLE; step-1 values (pattern 0011) retained
    pattern = 4'b0011;
    bus_write(3'd1, 32'd3);
    base = pe_cnt;
    bus_write(3'd0, 32'd1);
    n = 0;
    while (!((pe_cnt - base) == 2 && proba_signal) && n < 2000) begin
      @(negedge REFCLK);
      n++;
    end
    chk("abort_reach_sample2", {31'd0, (n < 2000)}, 32'd1);
    repeat (10) @(negedge REFCLK);
    bus_write(3'd0, 32'd4);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("abort_idle_proba", {31'd0, proba_signal}, 32'd0);
    bus_read(3'd2, rd); chk("abort_status", rd, 32'h0001_0004);
    bus_write(3'd3, 32'd1); bus_read(3'd4, rd); chk("abort_ch1", rd, 32'd100);
    bus_read(3'd5, rd); chk("abort_total", rd, 32'd200);
    repeat (300) @(negedge REFCLK);
    chk("abort_no_ps_en", pe_cnt - base, 32'd2);

    // STEPS = 0 goes straight to DONE with no ps_en
    bus_write(3'd1, 32'd0);
    base = pe_cnt;
    bus_write(3'd0, 32'd1);
    @(negedge REFCLK);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    bus_read(3'd2, rd); chk("zero_status", rd, 32'h0000_0002);
    chk("zero_ps_en", pe_cnt - base, 32'd0);

    // Start while busy is ignored (direction stays 0, one step only)
    bus_write(3'd1, 32'd1);
    base = pe_cnt;
    bus_write(3'd0, 32'd1);
    repeat (20) @(negedge REFCLK);
    bus_write(3'd0, 32'd3);
    chk("busy_start_dir", {31'd0, ps_incdec}, 32'd0);
    wait_idle(1000);
    chk("busy_start_ps_en", pe_cnt - base, 32'd1);
    bus_read(3'd2, rd); chk("busy_start_status", rd, 32'h0001_0002);

    // ps_done never returned
    auto_done = 1'b0;
    bus_write(3'd0, 32'd1);
    repeat (40) @(negedge REFCLK);
    bus_read(3'd2, rd);
`ifdef FF_SWEEP_TIMEOUT_EN
    chk("timeout_status", rd, 32'h0000_000A);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
`else
    chk("nowait_status", rd, 32'h0000_0001);
    chk("nowait_busy", {31'd0, busy}, 32'd1);
`endif
    bus_write(3'd0, 32'd4);
    auto_done = 1'b1;
    repeat (5) @(negedge REFCLK);

    // Reset mid-sweep
    bus_write(3'd1, 32'd3);
    base = pe_cnt;
    bus_write(3'd0, 32'd1);
    repeat (30) @(negedge REFCLK);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ps_en", {31'd0, ps_en}, 32'd0);
    @(negedge REFCLK);
    rst_n = 1'b1;
    repeat (400) @(negedge REFCLK);
    chk("mid_rst_no_ps_en", pe_cnt - base, 32'd1);
    chk("mid_rst_idle", {31'd0, busy}, 32'd0);
    bus_read(3'd1, rd); chk("mid_rst_steps", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
